// File: rtl/calc3_port_sequencer.sv
// Per-port CALC-3 request issuer: allocates one of four tags per command,
// matches responses back to stored commands and times out lost ones.
module calc3_port_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [3:0]  in_d1,
    input  logic [3:0]  in_d2,
    input  logic [3:0]  in_r1,
    input  logic [31:0] in_data,
    output logic [3:0]  req_cmd,
    output logic [3:0]  req_d1,
    output logic [3:0]  req_d2,
    output logic [3:0]  req_r1,
    output logic [31:0] req_data,
    output logic [1:0]  req_tag,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        cpl_valid,
    output logic [3:0]  cpl_cmd,
    output logic [1:0]  cpl_tag,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic        cpl_timeout,
    output logic [2:0]  outstanding,
    output logic        err_unexpected
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    logic             run_q;
    logic [3:0]       busy;
    logic [3:0]       cmd_mem [4];
    logic [CNT_W-1:0] cnt [4];

    logic       issue;
    logic [1:0] alloc_tag;
    logic [3:0] alloc_mask;
    logic       resp_hit;
    logic       resp_bad;
    logic [3:0] pend;
    logic       to_fire;
    logic [1:0] to_tag;
    logic [3:0] free_mask;
    logic [3:0] busy_nxt;
    logic [2:0] busy_cnt;

    // run_q keeps in_ready low until the first edge out of reset
    assign in_ready = run_q & ~&busy;
    assign issue    = in_valid & in_ready & (in_cmd != 4'd0);

    always_comb begin
        alloc_tag = 2'd0;
        to_tag    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            pend[i] = busy[i] & (cnt[i] == TMO);
            if (!busy[i])
                alloc_tag = 2'(i);
            if (pend[i])
                to_tag = 2'(i);
        end
    end

    always_comb begin
        resp_hit = ((out_resp == 2'd1) || (out_resp == 2'd2)) & busy[out_tag];
        resp_bad = (out_resp != 2'd0) & ~resp_hit;
        to_fire  = ~resp_hit & (|pend);
        free_mask = 4'd0;
        if (resp_hit)
            free_mask = 4'd1 << out_tag;
        else if (to_fire)
            free_mask = 4'd1 << to_tag;
        alloc_mask = issue ? (4'd1 << alloc_tag) : 4'd0;
        busy_nxt = (busy & ~free_mask) | alloc_mask;
        busy_cnt = {2'd0, busy_nxt[0]} + {2'd0, busy_nxt[1]}
                 + {2'd0, busy_nxt[2]} + {2'd0, busy_nxt[3]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q          <= 1'b0;
            busy           <= 4'd0;
            outstanding    <= 3'd0;
            err_unexpected <= 1'b0;
            req_cmd        <= 4'd0;
            req_d1         <= 4'd0;
            req_d2         <= 4'd0;
            req_r1         <= 4'd0;
            req_data       <= 32'd0;
            req_tag        <= 2'd0;
            cpl_valid      <= 1'b0;
            cpl_cmd        <= 4'd0;
            cpl_tag        <= 2'd0;
            cpl_resp       <= 2'd0;
            cpl_data       <= 32'd0;
            cpl_timeout    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cmd_mem[i] <= 4'd0;
                cnt[i]     <= '0;
            end
        end else begin
            run_q          <= 1'b1;
            busy           <= busy_nxt;
            outstanding    <= busy_cnt;
            err_unexpected <= err_unexpected | resp_bad;

            req_cmd  <= issue ? in_cmd    : 4'd0;
            req_d1   <= issue ? in_d1     : 4'd0;
            req_d2   <= issue ? in_d2     : 4'd0;
            req_r1   <= issue ? in_r1     : 4'd0;
            req_data <= issue ? in_data   : 32'd0;
            req_tag  <= issue ? alloc_tag : 2'd0;

            for (int i = 0; i < 4; i++) begin
                if (alloc_mask[i])
                    cnt[i] <= '0;
                else if (busy[i] && cnt[i] != TMO)
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (issue)
                cmd_mem[alloc_tag] <= in_cmd;

            cpl_valid   <= 1'b0;
            cpl_cmd     <= 4'd0;
            cpl_tag     <= 2'd0;
            cpl_resp    <= 2'd0;
            cpl_data    <= 32'd0;
            cpl_timeout <= 1'b0;
            // a real response always beats a pending timeout
            unique case (1'b1)
                resp_hit: begin
                    cpl_valid <= 1'b1;
                    cpl_cmd   <= cmd_mem[out_tag];
                    cpl_tag   <= out_tag;
                    cpl_resp  <= out_resp;
                    cpl_data  <= out_data;
                end
                to_fire: begin
                    cpl_valid   <= 1'b1;
                    cpl_cmd     <= cmd_mem[to_tag];
                    cpl_tag     <= to_tag;
                    cpl_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc3_port_sequencer.sv
// Bench for calc3_port_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a tag-table model keyed on issue cycle.
module tb_calc3_port_sequencer;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd, in_d1, in_d2, in_r1;
    logic [31:0] in_data;
    logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
    logic [31:0] req_data;
    logic [1:0]  req_tag;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        cpl_valid;
    logic [3:0]  cpl_cmd;
    logic [1:0]  cpl_tag;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic        cpl_timeout;
    logic [2:0]  outstanding;
    logic        err_unexpected;

    calc3_port_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_d1(in_d1), .in_d2(in_d2), .in_r1(in_r1),
        .in_data(in_data),
        .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2),
        .req_r1(req_r1), .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .cpl_valid(cpl_valid), .cpl_cmd(cpl_cmd), .cpl_tag(cpl_tag),
        .cpl_resp(cpl_resp), .cpl_data(cpl_data),
        .cpl_timeout(cpl_timeout), .outstanding(outstanding),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference model: tag table with issue cycle; timeout when age > TMO
    bit          m_ok = 1'b0;
    bit          m_run;
    bit          m_busy [4];
    logic [3:0]  m_cmd [4];
    int          m_iss [4];
    bit          m_err;
    int          cyc = 0;
    logic        e_ready, e_cpl_valid, e_cpl_to, e_err;
    logic [3:0]  e_req_cmd, e_req_d1, e_req_d2, e_req_r1, e_cpl_cmd;
    logic [31:0] e_req_data, e_cpl_data;
    logic [1:0]  e_req_tag, e_cpl_tag, e_cpl_resp;
    logic [2:0]  e_out;
    int          nb, pt, ft;
    bit          acc, hit;

    always @(posedge clk) begin
        e_req_cmd = 0; e_req_d1 = 0; e_req_d2 = 0; e_req_r1 = 0;
        e_req_data = 0; e_req_tag = 0;
        e_cpl_valid = 0; e_cpl_cmd = 0; e_cpl_tag = 0;
        e_cpl_resp = 0; e_cpl_data = 0; e_cpl_to = 0;
        if (!reset_n) begin
            m_ok = 1'b1;
            m_run = 1'b0;
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
        end else begin
            nb = 0;
            for (int i = 0; i < 4; i++) nb += int'(m_busy[i]);
            acc = in_valid && m_run && nb < 4;
            hit = (out_resp == 2'd1 || out_resp == 2'd2) && m_busy[out_tag];
            if (out_resp != 2'd0 && !hit) m_err = 1'b1;
            pt = -1; ft = -1;
            for (int i = 0; i < 4; i++) begin
                if (pt < 0 && m_busy[i] && (cyc - m_iss[i]) > TMO) pt = i;
                if (ft < 0 && !m_busy[i]) ft = i;
            end
            if (hit) begin
                e_cpl_valid = 1; e_cpl_cmd = m_cmd[out_tag];
                e_cpl_tag = out_tag; e_cpl_resp = out_resp;
                e_cpl_data = out_data;
                m_busy[out_tag] = 1'b0;
            end else if (pt >= 0) begin
                e_cpl_valid = 1; e_cpl_cmd = m_cmd[pt];
                e_cpl_tag = 2'(pt); e_cpl_to = 1;
                m_busy[pt] = 1'b0;
            end
            if (acc && in_cmd != 4'd0) begin
                m_busy[ft] = 1'b1;
                m_cmd[ft] = in_cmd;
                m_iss[ft] = cyc;
                e_req_cmd = in_cmd; e_req_d1 = in_d1; e_req_d2 = in_d2;
                e_req_r1 = in_r1; e_req_data = in_data;
                e_req_tag = 2'(ft);
            end
            m_run = 1'b1;
        end
        nb = 0;
        for (int i = 0; i < 4; i++) nb += int'(m_busy[i]);
        e_out = 3'(nb);
        e_ready = m_run && nb < 4;
        e_err = m_err;
        cyc++;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("req_cmd", 32'(req_cmd), 32'(e_req_cmd));
            chk("req_d1", 32'(req_d1), 32'(e_req_d1));
            chk("req_d2", 32'(req_d2), 32'(e_req_d2));
            chk("req_r1", 32'(req_r1), 32'(e_req_r1));
            chk("req_data", req_data, e_req_data);
            chk("req_tag", 32'(req_tag), 32'(e_req_tag));
            chk("cpl_valid", 32'(cpl_valid), 32'(e_cpl_valid));
            chk("cpl_cmd", 32'(cpl_cmd), 32'(e_cpl_cmd));
            chk("cpl_tag", 32'(cpl_tag), 32'(e_cpl_tag));
            chk("cpl_resp", 32'(cpl_resp), 32'(e_cpl_resp));
            chk("cpl_data", cpl_data, e_cpl_data);
            chk("cpl_timeout", 32'(cpl_timeout), 32'(e_cpl_to));
            chk("outstanding", 32'(outstanding), 32'(e_out));
            chk("err_unexpected", 32'(err_unexpected), 32'(e_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_cmd = 0; in_d1 = 0; in_d2 = 0; in_r1 = 0;
        in_data = 0; out_resp = 0; out_data = 0; out_tag = 0;
    endtask

    task automatic put(input logic [3:0] c, input logic [31:0] d);
        in_valid = 1; in_cmd = c; in_d1 = 4'd3; in_d2 = 4'd4;
        in_r1 = 4'd5; in_data = d;
    endtask

    task automatic resp(input logic [1:0] r, input logic [1:0] t,
                        input logic [31:0] d);
        out_resp = r; out_tag = t; out_data = d;
    endtask

    initial begin
        idle();
        reset_n = 0;
        put(4'd3, 32'h1);
        tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_req", 32'(req_cmd), 32'd0);
        chk("rst_cpl", 32'(cpl_valid), 32'd0);
        idle();
        reset_n = 1;
        tick();
        chk("rel_ready", 32'(in_ready), 32'd1);

        put(4'd1, 32'h0);
        tick();
        chk("add_req_cmd", 32'(req_cmd), 32'd1);
        chk("add_req_tag", 32'(req_tag), 32'd0);
        chk("add_req_d2", 32'(req_d2), 32'd4);
        idle();
        tick();
        chk("add_req_gone", 32'(req_cmd), 32'd0);
        resp(2'd1, 2'd0, 32'h7);
        tick();
        chk("add_cpl_valid", 32'(cpl_valid), 32'd1);
        chk("add_cpl_cmd", 32'(cpl_cmd), 32'd1);
        chk("add_cpl_data", cpl_data, 32'd7);
        chk("add_outst", 32'(outstanding), 32'd0);
        idle();

        for (int i = 0; i < 4; i++) begin
            put(4'd2, 32'(i));
            tick();
            chk("b2b_tag", 32'(req_tag), 32'(i));
        end
        put(4'd2, 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_outst", 32'(outstanding), 32'd4);
        resp(2'd2, 2'd2, 32'hbad);
        tick();
        chk("err_cpl_tag", 32'(cpl_tag), 32'd2);
        chk("err_cpl_resp", 32'(cpl_resp), 32'd2);
        resp(2'd0, 2'd0, 32'd0);
        tick();
        chk("fifth_tag", 32'(req_tag), 32'd2);
        chk("fifth_cmd", 32'(req_cmd), 32'd2);
        idle();
        repeat (25) tick();
        chk("drain_outst", 32'(outstanding), 32'd0);

        put(4'd5, 32'd0); tick();
        put(4'd6, 32'd0); tick();
        idle();
        repeat (7) tick();
        chk("pre_to", 32'(cpl_valid), 32'd0);
        tick();
        chk("to0_valid", 32'(cpl_timeout), 32'd1);
        chk("to0_tag", 32'(cpl_tag), 32'd0);
        chk("to0_cmd", 32'(cpl_cmd), 32'd5);
        tick();
        chk("to1_valid", 32'(cpl_timeout), 32'd1);
        chk("to1_tag", 32'(cpl_tag), 32'd1);
        resp(2'd1, 2'd0, 32'h9);
        tick();
        chk("late_err", 32'(err_unexpected), 32'd1);
        chk("late_nocpl", 32'(cpl_valid), 32'd0);
        idle();

        put(4'd8, 32'd0); tick();
        put(4'd9, 32'd0); tick();
        idle();
        repeat (7) tick();
        resp(2'd1, 2'd1, 32'h55);
        tick();
        chk("race_tag", 32'(cpl_tag), 32'd1);
        chk("race_to", 32'(cpl_timeout), 32'd0);
        chk("race_data", cpl_data, 32'h55);
        idle();
        tick();
        chk("race_to_tag", 32'(cpl_tag), 32'd0);
        chk("race_to_flag", 32'(cpl_timeout), 32'd1);

        for (int i = 0; i < 3; i++) begin
            put(4'd7, 32'(i));
            tick();
        end
        idle();
        chk("pre_rst_outst", 32'(outstanding), 32'd3);
        reset_n = 0;
        tick();
        chk("rst3_outst", 32'(outstanding), 32'd0);
        chk("rst3_err", 32'(err_unexpected), 32'd0);
        reset_n = 1;
        tick();
        put(4'd4, 32'd0);
        tick();
        chk("rst3_tag", 32'(req_tag), 32'd0);
        chk("rst3_cmd", 32'(req_cmd), 32'd4);
        idle();
        repeat (12) tick();

        for (int n = 0; n < 3000; n++) begin
            int r;
            reset_n = ($urandom_range(0, 499) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_cmd = 4'($urandom_range(0, 15));
            in_d1 = 4'($urandom_range(0, 15));
            in_d2 = 4'($urandom_range(0, 15));
            in_r1 = 4'($urandom_range(0, 15));
            in_data = $urandom;
            r = int'($urandom_range(0, 9));
            out_resp = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            out_tag = 2'($urandom_range(0, 3));
            out_data = $urandom;
            tick();
        end
        reset_n = 1;
        idle();
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
